// File: rtl/sprite_pkg.sv
// sprite_pkg: shared screen/sprite geometry, colours and bounce helpers
package sprite_pkg;
    localparam int H_RES = 640;
    localparam int V_RES = 480;
    localparam int SPR_W = 208;
    localparam int SPR_H = 208;
    localparam logic [2:0] FG_COLOR = 3'b111;
    localparam logic [2:0] BG_COLOR = 3'b001;
    localparam logic [9:0] X_RESET = 10'd216;
    localparam logic [9:0] Y_RESET = 10'd136;
    localparam logic [9:0] X_MAX = 10'(H_RES - SPR_W);
    localparam logic [9:0] Y_MAX = 10'(V_RES - SPR_H);

    typedef enum logic {DIR_INC = 1'b0, DIR_DEC = 1'b1} dir_t;

    // An edge hit reverses and steps away from the edge within the same update.
    function automatic logic [9:0] next_pos(input logic [9:0] pos, input dir_t dir, input logic [9:0] lim);
        return (dir == DIR_DEC) ? ((pos == 10'd0) ? 10'd1 : pos - 10'd1)
                                : ((pos == lim) ? lim - 10'd1 : pos + 10'd1);
    endfunction

    function automatic dir_t next_dir(input logic [9:0] pos, input dir_t dir, input logic [9:0] lim);
        return (dir == DIR_DEC) ? ((pos == 10'd0) ? DIR_INC : DIR_DEC)
                                : ((pos == lim) ? DIR_DEC : DIR_INC);
    endfunction
endpackage

// File: rtl/sprite_motion.sv
// sprite_motion: sprite origin registers, bouncing off the screen edges once per frame
import sprite_pkg::*;

module sprite_motion (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       move_en,
    output logic [9:0] sprite_x,
    output logic [9:0] sprite_y
);
    dir_t dx;
    dir_t dy;

    always_ff @(posedge clk) begin
        if (reset) begin
            sprite_x <= X_RESET;
            sprite_y <= Y_RESET;
            dx       <= DIR_INC;
            dy       <= DIR_INC;
        end else if (frame_tick && move_en) begin
            sprite_x <= next_pos(sprite_x, dx, X_MAX);
            sprite_y <= next_pos(sprite_y, dy, Y_MAX);
            dx       <= next_dir(sprite_x, dx, X_MAX);
            dy       <= next_dir(sprite_y, dy, Y_MAX);
        end
    end
endmodule

// File: rtl/sprite_renderer.sv
// sprite_renderer: two-stage pixel pipeline mapping scan position to ROM row/bit and colour
import sprite_pkg::*;

module sprite_renderer (
    input  logic             clk,
    input  logic             reset,
    input  logic [9:0]       pixel_x,
    input  logic [9:0]       pixel_y,
    input  logic             video_on,
    input  logic             frame_tick,
    input  logic             move_en,
    output logic [7:0]       rom_addr,
    input  logic [SPR_W-1:0] rom_data,
    output logic [2:0]       rgb,
    output logic [9:0]       sprite_x,
    output logic [9:0]       sprite_y
);
    logic       hit;
    logic       hit_q;
    logic       von_q;
    logic [7:0] row_q;
    logic [7:0] col_q;
    logic [7:0] bit_idx;

    sprite_motion u_motion (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .move_en    (move_en),
        .sprite_x   (sprite_x),
        .sprite_y   (sprite_y)
    );

    // 11-bit compares keep origin + size from wrapping.
    assign hit = ({1'b0, pixel_x} >= {1'b0, sprite_x})
              && ({1'b0, pixel_x} <= {1'b0, sprite_x} + 11'(SPR_W - 1))
              && ({1'b0, pixel_y} >= {1'b0, sprite_y})
              && ({1'b0, pixel_y} <= {1'b0, sprite_y} + 11'(SPR_H - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_q <= 1'b0;
            von_q <= 1'b0;
            row_q <= 8'd0;
            col_q <= 8'd0;
        end else begin
            hit_q <= hit;
            von_q <= video_on;
            row_q <= 8'(pixel_y - sprite_y);
            col_q <= 8'(pixel_x - sprite_x);
        end
    end

    assign rom_addr = hit_q ? row_q : 8'd0;
    // Column 0 is the leftmost pixel, stored in the row MSB.
    assign bit_idx  = 8'(SPR_W - 1) - col_q;

    always_ff @(posedge clk) begin
        if (reset)
            rgb <= 3'd0;
        else
            rgb <= !von_q ? 3'd0 : (hit_q && rom_data[bit_idx]) ? FG_COLOR : BG_COLOR;
    end
endmodule

// File: tb/tb_sprite_renderer.sv
// tb_sprite_renderer: directed vector and sequence checks for sprite_renderer
import sprite_pkg::*;

module tb_sprite_renderer;
    logic             clk = 1'b0;
    logic             reset;
    logic [9:0]       pixel_x;
    logic [9:0]       pixel_y;
    logic             video_on;
    logic             frame_tick;
    logic             move_en;
    logic [7:0]       rom_addr;
    logic [SPR_W-1:0] rom_data;
    logic [2:0]       rgb;
    logic [9:0]       sprite_x;
    logic [9:0]       sprite_y;
    int               total = 0;
    int               bad = 0;

    typedef struct {
        logic [9:0] px;
        logic [9:0] py;
        logic       von;
        logic [7:0] addr;
        logic [2:0] col;
    } vec_t;

    vec_t vecs[10];

    sprite_renderer dut (
        .clk        (clk),
        .reset      (reset),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .video_on   (video_on),
        .frame_tick (frame_tick),
        .move_en    (move_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rgb        (rgb),
        .sprite_x   (sprite_x),
        .sprite_y   (sprite_y)
    );

    always #5 clk = ~clk;

    // ROM stand-in: bit b of row r is set when (r + b) is a multiple of 3.
    always_comb begin
        rom_data = '0;
        for (int b = 0; b < SPR_W; b++)
            rom_data[b] = ((int'(rom_addr) + b) % 3) == 0;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic v);
        pixel_x  = x;
        pixel_y  = y;
        video_on = v;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic chk_pos(input string nm, input int x, input int y);
        chk({nm, ".x"}, int'(sprite_x), x);
        chk({nm, ".y"}, int'(sprite_y), y);
    endtask

    initial begin
        vecs[0] = '{10'd216, 10'd136, 1'b1, 8'd0,   FG_COLOR};
        vecs[1] = '{10'd300, 10'd259, 1'b1, 8'd123, FG_COLOR};
        vecs[2] = '{10'd400, 10'd205, 1'b1, 8'd69,  BG_COLOR};
        vecs[3] = '{10'd215, 10'd136, 1'b1, 8'd0,   BG_COLOR};
        vecs[4] = '{10'd424, 10'd136, 1'b1, 8'd0,   BG_COLOR};
        vecs[5] = '{10'd300, 10'd259, 1'b0, 8'd123, 3'd0};
        vecs[6] = '{10'd423, 10'd343, 1'b1, 8'd207, FG_COLOR};
        vecs[7] = '{10'd216, 10'd344, 1'b1, 8'd0,   BG_COLOR};
        vecs[8] = '{10'd217, 10'd136, 1'b1, 8'd0,   BG_COLOR};
        vecs[9] = '{10'd0,   10'd0,   1'b0, 8'd0,   3'd0};

        reset = 1'b1;
        frame_tick = 1'b0;
        move_en = 1'b0;
        drive(10'd0, 10'd0, 1'b0);
        repeat (3) @(negedge clk);
        chk("reset.rgb", int'(rgb), 0);
        chk("reset.addr", int'(rom_addr), 0);
        chk_pos("reset", 216, 136);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].px, vecs[i].py, vecs[i].von);
            @(negedge clk);
            chk($sformatf("vec%0d.addr", i), int'(rom_addr), int'(vecs[i].addr));
            @(negedge clk);
            chk($sformatf("vec%0d.rgb", i), int'(rgb), int'(vecs[i].col));
        end

        // Back-to-back pixels: one result per cycle, two cycles behind the input.
        drive(10'd300, 10'd259, 1'b1);
        @(negedge clk);
        chk("stream.addr_a", int'(rom_addr), 123);
        drive(10'd400, 10'd205, 1'b1);
        @(negedge clk);
        chk("stream.rgb_a", int'(rgb), int'(FG_COLOR));
        chk("stream.addr_b", int'(rom_addr), 69);
        drive(10'd300, 10'd259, 1'b0);
        @(negedge clk);
        chk("stream.rgb_b", int'(rgb), int'(BG_COLOR));
        chk("stream.addr_c", int'(rom_addr), 123);
        @(negedge clk);
        chk("stream.rgb_c", int'(rgb), 0);

        move_en = 1'b1;
        repeat (216) tick();
        chk_pos("run216", 432, 192);
        tick();
        chk_pos("bounce_x", 431, 191);
        tick();
        chk_pos("after_bounce", 430, 190);
        move_en = 1'b0;
        tick();
        chk_pos("move_off", 430, 190);

        force dut.u_motion.sprite_x = 10'd0;
        force dut.u_motion.sprite_y = 10'd5;
        force dut.u_motion.dx = DIR_DEC;
        force dut.u_motion.dy = DIR_DEC;
        @(negedge clk);
        release dut.u_motion.sprite_x;
        release dut.u_motion.sprite_y;
        release dut.u_motion.dx;
        release dut.u_motion.dy;
        @(negedge clk);
        chk_pos("preset_left", 0, 5);
        move_en = 1'b1;
        tick();
        chk_pos("left_edge", 1, 4);
        tick();
        chk_pos("left_after", 2, 3);
        move_en = 1'b0;

        force dut.u_motion.sprite_x = 10'd432;
        force dut.u_motion.sprite_y = 10'd272;
        force dut.u_motion.dx = DIR_INC;
        force dut.u_motion.dy = DIR_INC;
        @(negedge clk);
        release dut.u_motion.sprite_x;
        release dut.u_motion.sprite_y;
        release dut.u_motion.dx;
        release dut.u_motion.dy;
        @(negedge clk);
        chk_pos("preset_corner", 432, 272);
        move_en = 1'b1;
        tick();
        chk_pos("corner", 431, 271);
        tick();
        chk_pos("corner_after", 430, 270);
        move_en = 1'b0;

        // Mid-line reset while the sprite's top-left (set) pixel is on screen.
        drive(10'd430, 10'd270, 1'b1);
        repeat (2) @(negedge clk);
        chk("pre_reset.rgb", int'(rgb), int'(FG_COLOR));
        reset = 1'b1;
        @(negedge clk);
        chk("midreset.rgb", int'(rgb), 0);
        chk("midreset.addr", int'(rom_addr), 0);
        chk_pos("midreset", 216, 136);
        move_en = 1'b1;
        tick();
        move_en = 1'b0;
        chk_pos("tick_in_reset", 216, 136);
        reset = 1'b0;
        drive(10'd216, 10'd136, 1'b1);
        @(negedge clk);
        chk("refill1.rgb", int'(rgb), 0);
        chk("refill1.addr", int'(rom_addr), 0);
        @(negedge clk);
        chk("refill2.rgb", int'(rgb), int'(FG_COLOR));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sprite_renderer.md
# sprite_renderer

Pixel-pipeline stage placed directly upstream of the triangle ROM (8-bit row address in, 208-bit row data out) and downstream of the VGA sync generator. It converts the current scan coordinate into a ROM row address, selects the addressed bit from the returned row, and drives the pixel colour. A frame-rate motion counter moves the sprite origin and bounces it off the screen edges.

## Interface
- H_RES, 640: visible columns.
- V_RES, 480: visible rows.
- SPR_W, 208: sprite width in pixels; equals the ROM data width.
- SPR_H, 208: sprite height in rows; must be ≤ 256.
- FG_COLOR, 3'b111: colour of a set ROM bit.
- BG_COLOR, 3'b001: colour of a visible pixel that is outside the sprite or on a clear ROM bit.

- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high.
- pixel_x  in  10  current scan column from the sync generator.
- pixel_y  in  10  current scan row.
- video_on  in  1  high inside the visible area.
- frame_tick  in  1  one-cycle pulse, asserted once per frame during vertical blanking.
- move_en  in  1  enables motion updates on frame_tick.
- rom_addr  out  8  row address to the ROM.
- rom_data  in  208  row bits from the combinational ROM.
- rgb  out  3  pixel colour.
- sprite_x  out  10  current sprite origin column.
- sprite_y  out  10  current sprite origin row.

## Operation
- Hit test: a pixel is a hit when sprite_x ≤ pixel_x ≤ sprite_x+SPR_W−1 and sprite_y ≤ pixel_y ≤ sprite_y+SPR_H−1. Compare at 11 bits so the sums cannot overflow.
- Stage 1 (registered):
  - row = pixel_y − sprite_y, truncated to 8 bits; col = pixel_x − sprite_x, 8 bits.
  - Register hit and video_on alongside row and col.
  - rom_addr is the registered row when hit, else 8'd0.
- Stage 2 (registered): compute the output colour from the stage-1 values.
  - rgb = 0 when video_on is low.
  - rgb = FG_COLOR when hit and rom_data[SPR_W−1−col] = 1. Column 0 is the MSB, so the leftmost pixel is bit 207.
  - rgb = BG_COLOR otherwise.
- Motion state: direction bits dx and dy, each 0 = increasing, 1 = decreasing.
- Motion update on frame_tick & move_en, with x and y handled independently:
  - When moving right with sprite_x = H_RES−SPR_W (432), set dx=1 and sprite_x = 431 in the same update.
  - When moving left with sprite_x = 0, set dx=0 and sprite_x = 1.
  - Otherwise sprite_x steps by ±1.
  - Y uses the same rules with V_RES−SPR_H (272) as the upper limit.
- frame_tick with move_en low: no change.
- A corner hit reverses both axes in the same update.

## Timing
- Latency: pixel_x/pixel_y/video_on to rgb is exactly 2 clk cycles.
  - The sync generator must delay hsync/vsync by 2 cycles to stay aligned; that delay is not done in this block.
- rom_addr changes 1 cycle after the input coordinate. rom_data is sampled in the next cycle; the ROM is combinational with zero latency.
- sprite_x/sprite_y update on the clock edge after frame_tick and stay constant for the whole frame, so there is no tearing.
- Reset values:
  - rgb = 0, rom_addr = 0.
  - Stage registers cleared; hit = 0, video_on = 0.
  - sprite_x = 216, sprite_y = 136 (centred); dx = 0, dy = 0.
- Reset mid-frame: rgb is 0 on the cycle after reset is sampled. The pipeline refills normally 2 cycles after reset deasserts.
- frame_tick coinciding with reset: reset wins and the position is not updated.

## Structure
- Package sprite_pkg holds:
  - H_RES, V_RES, SPR_W, SPR_H.
  - Colour constants FG_COLOR and BG_COLOR.
  - Reset origin values 216 and 136.
- Sub-module sprite_motion holds the origin and direction registers and the bounce logic.
  - Inputs: clk, reset, frame_tick, move_en.
  - Outputs: sprite_x, sprite_y.
- The top level holds the two pipeline stages and the ROM bit select.

## Test plan
- Reset, then pixel (216,136) with video_on → rom_addr=0 after 1 cycle; rgb = FG_COLOR if rom_data[207]=1, else BG_COLOR, after 2 cycles.
- Pixel (300,259) → rom_addr=123, bit select col=84 → rom_data[123] checked against rgb; then pixel (400,205) → rom_addr=69, col=184, rom_data[23].
- Pixel (215,136) and pixel (424,136): outside the sprite → rgb=BG_COLOR and rom_addr=0. Any pixel with video_on=0 → rgb=0.
- move_en=1, 216 frame_ticks → sprite_x=432, dx=0; next tick → sprite_x=431, dx=1. From (0, 5) moving left and up: next tick → (1, 4).
- Force corner (432,272) moving right and down, then one tick → (431,271) with both directions reversed. frame_tick with move_en=0 → position unchanged.
- Assert reset mid-line while rgb=FG_COLOR → rgb=0 on the next edge and origin returns to (216,136). Assert frame_tick together with reset → no motion.
